// File: rtl/video_timing_gen_if.sv
// rtl/video_timing_gen_if.sv - timing reprogramming handshake bundle
interface video_timing_gen_if #(
  parameter int CNT_W = 12
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_pending;
  logic [CNT_W-2:0] cfg_h_res;
  logic [CNT_W-2:0] cfg_h_fp;
  logic [CNT_W-2:0] cfg_h_sync;
  logic [CNT_W-2:0] cfg_h_bp;
  logic [CNT_W-2:0] cfg_v_res;
  logic [CNT_W-2:0] cfg_v_fp;
  logic [CNT_W-2:0] cfg_v_sync;
  logic [CNT_W-2:0] cfg_v_bp;
  logic             cfg_hpol;
  logic             cfg_vpol;

  modport master (
    output cfg_valid, cfg_h_res, cfg_h_fp, cfg_h_sync, cfg_h_bp,
           cfg_v_res, cfg_v_fp, cfg_v_sync, cfg_v_bp, cfg_hpol, cfg_vpol,
    input  cfg_ready, cfg_pending
  );

  modport slave (
    input  cfg_valid, cfg_h_res, cfg_h_fp, cfg_h_sync, cfg_h_bp,
           cfg_v_res, cfg_v_fp, cfg_v_sync, cfg_v_bp, cfg_hpol, cfg_vpol,
    output cfg_ready, cfg_pending
  );
endinterface

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - H/V timing generator with frame-aligned reprogramming
module video_timing_gen #(
  parameter int CNT_W  = 12,
  parameter int H_RES  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_RES  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [1:0]              step_log2,
  video_timing_gen_if.slave       cfg,
  output logic signed [CNT_W-1:0] hcount,
  output logic signed [CNT_W-1:0] vcount,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    hblank,
  output logic                    vblank,
  output logic                    de,
  output logic                    line_start,
  output logic                    frame_start
);

  localparam int FW = CNT_W - 1;
  localparam int EW = CNT_W + 1;

  typedef struct packed {
    logic [FW-1:0] h_res;
    logic [FW-1:0] h_fp;
    logic [FW-1:0] h_sync;
    logic [FW-1:0] h_bp;
    logic [FW-1:0] v_res;
    logic [FW-1:0] v_fp;
    logic [FW-1:0] v_sync;
    logic [FW-1:0] v_bp;
    logic          hpol;
    logic          vpol;
  } timing_t;

  localparam timing_t RST_SET = '{FW'(H_RES), FW'(H_FP), FW'(H_SYNC), FW'(H_BP),
                                  FW'(V_RES), FW'(V_FP), FW'(V_SYNC), FW'(V_BP),
                                  1'b0, 1'b0};
  localparam logic signed [CNT_W-1:0] HC_RST = CNT_W'(-(H_FP + H_SYNC + H_BP));
  localparam logic signed [CNT_W-1:0] VC_RST = CNT_W'(-(V_FP + V_SYNC + V_BP));
  localparam logic signed [CNT_W-1:0] V_ONE  = 1;
  localparam logic signed [EW-1:0]    ONE_X  = 1;

  timing_t act;
  timing_t shd;
  timing_t cfg_in;
  timing_t nxt;
  logic    pending;

  function automatic logic signed [EW-1:0] ext(input logic [FW-1:0] v);
    return $signed({2'b00, v});
  endfunction

  // Start-of-line/frame coordinate; BL may reach 2^(CNT_W-1), so sum one bit wider.
  function automatic logic signed [CNT_W-1:0] neg_bl(input logic [FW-1:0] fp,
                                                     input logic [FW-1:0] sync,
                                                     input logic [FW-1:0] bp);
    logic [EW-1:0] s;
    logic [EW-1:0] n;
    s = {2'b00, fp} + {2'b00, sync} + {2'b00, bp};
    n = -s;
    return n[CNT_W-1:0];
  endfunction

  logic signed [EW-1:0] hc_x;
  logic signed [EW-1:0] vc_x;
  logic        [EW-1:0] h_step;
  logic signed [EW-1:0] h_next;
  logic                 line_wrap;
  logic                 frame_wrap;
  logic                 hsync_region;
  logic                 vsync_region;

  assign cfg_in = '{cfg.cfg_h_res, cfg.cfg_h_fp, cfg.cfg_h_sync, cfg.cfg_h_bp,
                    cfg.cfg_v_res, cfg.cfg_v_fp, cfg.cfg_v_sync, cfg.cfg_v_bp,
                    cfg.cfg_hpol, cfg.cfg_vpol};
  // A capture coinciding with a wrap sees pending==0 here, so it waits a frame.
  assign nxt    = pending ? shd : act;

  assign hc_x       = {hcount[CNT_W-1], hcount};
  assign vc_x       = {vcount[CNT_W-1], vcount};
  assign h_step     = EW'(1) << step_log2;
  assign h_next     = hc_x + $signed(h_step);
  assign line_wrap  = enable && (h_next >= ext(act.h_res));
  assign frame_wrap = line_wrap && (vc_x >= (ext(act.v_res) - ONE_X));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act         <= RST_SET;
      shd         <= RST_SET;
      pending     <= 1'b0;
      hcount      <= HC_RST;
      vcount      <= VC_RST;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= line_wrap;
      frame_start <= frame_wrap;
      if (frame_wrap) begin
        hcount <= neg_bl(nxt.h_fp, nxt.h_sync, nxt.h_bp);
        vcount <= neg_bl(nxt.v_fp, nxt.v_sync, nxt.v_bp);
        if (pending) begin
          act     <= shd;
          pending <= 1'b0;
        end
      end else if (line_wrap) begin
        hcount <= neg_bl(act.h_fp, act.h_sync, act.h_bp);
        vcount <= vcount + V_ONE;
      end else if (enable) begin
        hcount <= h_next[CNT_W-1:0];
      end
      if (cfg.cfg_valid && !pending) begin
        shd     <= cfg_in;
        pending <= 1'b1;
      end
    end
  end

  // Sync window is [-(sync+bp), -bp); an empty window when sync is zero.
  assign hsync_region = (hc_x >= -(ext(act.h_sync) + ext(act.h_bp))) && (hc_x < -ext(act.h_bp));
  assign vsync_region = (vc_x >= -(ext(act.v_sync) + ext(act.v_bp))) && (vc_x < -ext(act.v_bp));

  assign hsync  = hsync_region ^ act.hpol;
  assign vsync  = vsync_region ^ act.vpol;
  assign hblank = hcount[CNT_W-1];
  assign vblank = vcount[CNT_W-1];
  assign de     = !hblank && !vblank;

  assign cfg.cfg_ready   = !pending;
  assign cfg.cfg_pending = pending;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - directed self-checking bench for video_timing_gen
module tb_video_timing_gen;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               enable;
  logic [1:0]         step_log2;
  logic signed [11:0] hcount;
  logic signed [11:0] vcount;
  logic hsync, vsync, hblank, vblank, de, line_start, frame_start;

  int checks   = 0;
  int failures = 0;

  video_timing_gen_if #(.CNT_W(12)) cfg_bus ();

  video_timing_gen dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .step_log2   (step_log2),
    .cfg         (cfg_bus),
    .hcount      (hcount),
    .vcount      (vcount),
    .hsync       (hsync),
    .vsync       (vsync),
    .hblank      (hblank),
    .vblank      (vblank),
    .de          (de),
    .line_start  (line_start),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_line(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!line_start && n < max);
  endtask

  task automatic wait_frame(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_start && n < max);
  endtask

  task automatic set_cfg(input int hr, input int hf, input int hs, input int hb,
                         input int vr, input int vf, input int vs, input int vb,
                         input logic hp, input logic vp);
    cfg_bus.cfg_h_res  = 11'(hr);
    cfg_bus.cfg_h_fp   = 11'(hf);
    cfg_bus.cfg_h_sync = 11'(hs);
    cfg_bus.cfg_h_bp   = 11'(hb);
    cfg_bus.cfg_v_res  = 11'(vr);
    cfg_bus.cfg_v_fp   = 11'(vf);
    cfg_bus.cfg_v_sync = 11'(vs);
    cfg_bus.cfg_v_bp   = 11'(vb);
    cfg_bus.cfg_hpol   = hp;
    cfg_bus.cfg_vpol   = vp;
  endtask

  initial begin
    int n;
    int hs_first, hs_last, hs_n, de_n, ls_n, h_max, hold_err, ls_i, prev;
    int low_n, low_in;
    bit found;

    reset_n = 1'b0;
    enable = 1'b0;
    step_log2 = 2'd0;
    cfg_bus.cfg_valid = 1'b0;
    set_cfg(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    check("rst_hcount", hcount, -160);
    check("rst_vcount", vcount, -45);
    check("rst_hblank", hblank, 1);
    check("rst_vblank", vblank, 1);
    check("rst_de", de, 0);
    check("rst_hsync", hsync, 0);
    check("rst_vsync", vsync, 0);
    check("rst_line_start", line_start, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_cfg_ready", cfg_bus.cfg_ready, 1);
    check("rst_cfg_pending", cfg_bus.cfg_pending, 0);

    // Default timing, step 1: one full line
    reset_n = 1'b1;
    enable = 1'b1;
    hs_first = 9999; hs_last = 9999; hs_n = 0; de_n = 0; ls_n = 0; h_max = -9999;
    for (int k = 1; k <= 800; k++) begin
      tick();
      if (k == 1) check("step1_first", hcount, -159);
      if (hsync) begin
        if (hs_n == 0) hs_first = hcount;
        hs_last = hcount;
        hs_n++;
      end
      if (int'(hcount) > h_max) h_max = hcount;
      de_n += int'(de);
      ls_n += int'(line_start);
    end
    check("hsync_first", hs_first, -144);
    check("hsync_last", hs_last, -49);
    check("hsync_width", hs_n, 96);
    check("hcount_max", h_max, 639);
    check("de_in_vblank", de_n, 0);
    check("line_start_once", ls_n, 1);
    check("wrap_hcount", hcount, -160);
    check("wrap_vcount", vcount, -44);
    check("wrap_line_start", line_start, 1);
    check("vsync_before", vsync, 0);

    repeat (9) wait_line(2000, n);
    check("line_len_800", n, 800);
    check("vsync_m35_v", vcount, -35);
    check("vsync_m35", vsync, 1);
    wait_line(2000, n);
    check("vsync_m34", vsync, 1);
    wait_line(2000, n);
    check("vsync_m33", vsync, 0);

    // step_log2 = 2
    step_log2 = 2'd2;
    tick();
    check("step4_first", hcount, -156);
    ls_n = 0;
    for (int k = 0; k < 198; k++) begin
      tick();
      ls_n += int'(line_start);
    end
    check("step4_last", hcount, 636);
    check("step4_no_ls", ls_n, 0);
    tick();
    check("step4_wrap", hcount, -160);
    check("step4_ls", line_start, 1);

    // enable toggled 1/0
    step_log2 = 2'd0;
    hold_err = 0; ls_n = 0; ls_i = -1; prev = hcount;
    for (int i = 0; i < 1600; i++) begin
      enable = (i % 2 == 0);
      tick();
      if (!enable && int'(hcount) != prev) hold_err++;
      if (line_start) begin
        ls_n++;
        ls_i = i;
      end
      prev = hcount;
    end
    check("toggle_hold", hold_err, 0);
    check("toggle_ls_n", ls_n, 1);
    check("toggle_ls_at", ls_i, 1598);
    check("toggle_ls_clear", line_start, 0);
    check("toggle_hcount", hcount, -160);
    enable = 1'b1;

    // Config mid-frame, second request while pending is ignored
    set_cfg(8, 1, 2, 1, 4, 1, 1, 1, 1'b0, 1'b0);
    cfg_bus.cfg_valid = 1'b1;
    tick();
    check("cap_ready_low", cfg_bus.cfg_ready, 0);
    check("cap_pending", cfg_bus.cfg_pending, 1);
    check("cap_old_timing", hcount, -159);
    set_cfg(16, 1, 2, 1, 4, 1, 1, 1, 1'b0, 1'b0);
    tick();
    check("cap2_pending", cfg_bus.cfg_pending, 1);
    cfg_bus.cfg_valid = 1'b0;
    wait_line(2000, n);
    step_log2 = 2'd3;
    wait_frame(60000, n);
    step_log2 = 2'd0;
    check("old_frame_rest", n, 51000);
    check("apply_hcount", hcount, -4);
    check("apply_vcount", vcount, -3);
    check("apply_ls", line_start, 1);
    check("apply_ready", cfg_bus.cfg_ready, 1);
    check("apply_pending", cfg_bus.cfg_pending, 0);
    hs_n = 0; n = 0;
    do begin
      tick();
      n++;
      if (hsync) hs_n++;
    end while (!line_start && n < 100);
    check("new_line_len", n, 12);
    check("new_hsync_n", hs_n, 2);
    wait_frame(200, n);
    check("new_frame_len", n + 12, 84);

    // Inverted hsync polarity
    set_cfg(8, 1, 2, 1, 4, 1, 1, 1, 1'b1, 1'b0);
    cfg_bus.cfg_valid = 1'b1;
    tick();
    cfg_bus.cfg_valid = 1'b0;
    wait_frame(200, n);
    check("hpol_frame", n, 83);
    low_n = 0; low_in = 0;
    for (int k = 0; k < 12; k++) begin
      if (!hsync) begin
        low_n++;
        if (hcount == -3 || hcount == -2) low_in++;
      end
      tick();
    end
    check("hpol_low_n", low_n, 2);
    check("hpol_low_in", low_in, 2);

    // Capture coincident with a frame wrap waits one more frame
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (hcount == 7 && vcount == 3) found = 1'b1;
      else tick();
    end
    check("coinc_found", int'(found), 1);
    set_cfg(4, 1, 1, 1, 4, 1, 1, 1, 1'b0, 1'b0);
    cfg_bus.cfg_valid = 1'b1;
    tick();
    cfg_bus.cfg_valid = 1'b0;
    check("coinc_fs", frame_start, 1);
    check("coinc_pending", cfg_bus.cfg_pending, 1);
    check("coinc_old_h", hcount, -4);
    wait_line(200, n);
    check("coinc_old_line", n, 12);
    wait_frame(200, n);
    check("coinc_old_frame", n, 72);
    check("coinc_new_h", hcount, -3);
    check("coinc_new_pending", cfg_bus.cfg_pending, 0);
    wait_line(200, n);
    check("coinc_new_line", n, 7);

    // Async reset mid-line while a config is pending
    set_cfg(8, 1, 2, 1, 4, 1, 1, 1, 1'b1, 1'b1);
    cfg_bus.cfg_valid = 1'b1;
    tick();
    cfg_bus.cfg_valid = 1'b0;
    check("rst2_pending_pre", cfg_bus.cfg_pending, 1);
    repeat (2) tick();
    #2 reset_n = 1'b0;
    #1;
    check("rst2_hcount", hcount, -160);
    check("rst2_vcount", vcount, -45);
    check("rst2_pending", cfg_bus.cfg_pending, 0);
    check("rst2_ready", cfg_bus.cfg_ready, 1);
    check("rst2_hsync", hsync, 0);
    check("rst2_hblank", hblank, 1);
    @(posedge clk);
    #1 reset_n = 1'b1;
    wait_line(2000, n);
    check("rst2_line_len", n, 800);
    check("rst2_vcount_next", vcount, -44);
    check("rst2_no_apply", cfg_bus.cfg_pending, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
